// File: rtl/apb_cmd_master.sv
// APB requester: accepts one valid/ready command, runs the SETUP/ACCESS transfer and
// returns the outcome on a valid/ready response channel, with an optional pready watchdog.
module apb_cmd_master #(
  parameter int unsigned AW        = 6,
  parameter int unsigned DW        = 32,
  parameter int unsigned TO_CYCLES = 16
) (
  input  logic          pclk,
  input  logic          preset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          rsp_timeout,
  output logic          psel,
  output logic          penable,
  output logic [AW-1:0] paddr,
  output logic          pwrite,
  output logic [DW-1:0] pwdata,
  input  logic [DW-1:0] prdata,
  input  logic          pready,
  input  logic          pslverr
);

  localparam int unsigned CW      = (TO_CYCLES > 0) ? $clog2(TO_CYCLES + 1) : 1;
  localparam int unsigned TO_LAST = (TO_CYCLES > 0) ? TO_CYCLES - 1 : 0;
  localparam bit          WDOG_EN = (TO_CYCLES != 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e          state_q, state_d;
  logic   [CW-1:0] count_q, count_d;
  logic            psel_q, psel_d;
  logic            penable_q, penable_d;
  logic   [AW-1:0] paddr_q, paddr_d;
  logic            pwrite_q, pwrite_d;
  logic   [DW-1:0] pwdata_q, pwdata_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic   [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;
  logic            rsp_timeout_q, rsp_timeout_d;

  assign cmd_ready   = (state_q == IDLE) & ~preset;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign paddr       = paddr_q;
  assign pwrite      = pwrite_q;
  assign pwdata      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

  // Next-state and registered-output logic
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          psel_d   = 1'b1;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        // pready takes priority over a watchdog expiring on the same edge
        if (pready) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = (pwrite_q || pslverr) ? '0 : prdata;
          rsp_err_d     = pslverr;
          rsp_timeout_d = 1'b0;
          state_d       = RESP;
        end else if (WDOG_EN && (count_q == CW'(TO_LAST))) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = RESP;
        end else if (WDOG_EN) begin
          count_d = count_q + CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          count_d     = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, synchronous reset
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q       <= IDLE;
      count_q       <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master: table of single transfers with a reactive completer,
// plus hand sequences for response backpressure and reset during ACCESS.
module tb_apb_cmd_master;

  logic        pclk = 1'b0;
  logic        preset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [5:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err, rsp_timeout;
  logic        psel, penable, pwrite;
  logic [5:0]  paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  apb_cmd_master #(.AW(6), .DW(32), .TO_CYCLES(4)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic        write;
    logic [5:0]  addr;
    logic [31:0] wdata;
    int          waits;   // ACCESS cycles before pready; >= 4 means never
    logic [31:0] prdata;
    logic        slverr;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
    int          exp_lat; // cycles from acceptance edge to rsp_valid
    int          exp_acc; // ACCESS cycles
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic issue(input logic wr, input logic [5:0] a, input logic [31:0] wd);
    @(negedge pclk);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = wd;
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    @(posedge pclk);
    #1 cmd_valid = 1'b0;
  endtask

  // Acts as the completer until rsp_valid is seen or the cycle budget runs out
  task automatic complete(input int waits, input logic [31:0] prd, input logic slv,
                          input logic [5:0] a, input logic wr, input logic [31:0] wd,
                          output int lat, output int acc, output int nsel);
    bit done = 1'b0;
    lat = 0; acc = 0; nsel = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge pclk);
      lat++;
      chk("penable_implies_psel", 32'(penable & ~psel), 32'd0);
      if (psel) begin
        nsel++;
        chk("paddr_stable", 32'(paddr), 32'(a));
        chk("pwrite_stable", 32'(pwrite), 32'(wr));
        chk("pwdata_stable", pwdata, wd);
      end
      if (psel && penable) begin
        pready  = (acc == waits);
        prdata  = pready ? prd : 32'h0;
        pslverr = pready ? slv : 1'b0;
        acc++;
      end else begin
        pready  = 1'b0;
        prdata  = 32'h0;
        pslverr = 1'b0;
      end
      if (rsp_valid) done = 1'b1;
    end
    if (!done) chk("rsp_valid_within_budget", 32'd0, 32'd1);
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge pclk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int lat, acc, nsel;
    issue(v.write, v.addr, v.wdata);
    complete(v.waits, v.prdata, v.slverr, v.addr, v.write, v.wdata, lat, acc, nsel);
    chk("latency", 32'(lat), 32'(v.exp_lat));
    chk("access_cycles", 32'(acc), 32'(v.exp_acc));
    chk("psel_cycles", 32'(nsel), 32'(v.exp_acc + 1));
    chk("rsp_rdata", rsp_rdata, v.exp_rdata);
    chk("rsp_err", 32'(rsp_err), 32'(v.exp_err));
    chk("rsp_timeout", 32'(rsp_timeout), 32'(v.exp_to));
    handshake();
    @(negedge pclk);
    chk("rsp_valid_cleared", 32'(rsp_valid), 32'd0);
    chk("paddr_held", 32'(paddr), 32'(v.addr));
    chk("cmd_ready_after", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int lat, acc, nsel;
    logic [31:0] held;

    //            wr    addr   wdata         waits prdata        slv   rdata         err   to    lat acc
    vecs[0] = '{1'b1, 6'h04, 32'hDEADBEEF, 0,  32'hAAAA5555, 1'b0, 32'h0,        1'b0, 1'b0, 3, 1};
    vecs[1] = '{1'b0, 6'h10, 32'h00000011, 3,  32'h12345678, 1'b0, 32'h12345678, 1'b0, 1'b0, 6, 4};
    vecs[2] = '{1'b0, 6'h08, 32'h00000022, 0,  32'hCAFEF00D, 1'b1, 32'h0,        1'b1, 1'b0, 3, 1};
    vecs[3] = '{1'b0, 6'h3F, 32'h00000033, 99, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 6, 4};
    vecs[4] = '{1'b0, 6'h2A, 32'h00000044, 3,  32'h0BADCAFE, 1'b0, 32'h0BADCAFE, 1'b0, 1'b0, 6, 4};
    vecs[5] = '{1'b1, 6'h01, 32'h5A5A5A5A, 1,  32'h77777777, 1'b1, 32'h0,        1'b1, 1'b0, 4, 2};

    preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_psel", 32'(psel), 32'd0);
    chk("rst_penable", 32'(penable), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_paddr", 32'(paddr), 32'd0);
    chk("rst_pwdata", pwdata, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_flags", 32'({pwrite, rsp_err, rsp_timeout}), 32'd0);
    preset = 1'b0;
    @(negedge pclk);
    chk("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Response backpressure with a second command waiting
    issue(1'b0, 6'h05, 32'h0);
    complete(0, 32'h11112222, 1'b0, 6'h05, 1'b0, 32'h0, lat, acc, nsel);
    held = rsp_rdata;
    chk("bp_rdata", held, 32'h11112222);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 6'h06; cmd_wdata = 32'h600DF00D;
    for (int i = 0; i < 5; i++) begin
      @(negedge pclk);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rdata_stable", rsp_rdata, held);
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    handshake();
    @(negedge pclk);
    chk("bp_rsp_dropped", 32'(rsp_valid), 32'd0);
    chk("bp_cmd_ready_next", 32'(cmd_ready), 32'd1);
    chk("bp_psel_idle", 32'(psel), 32'd0);
    @(posedge pclk);
    #1 cmd_valid = 1'b0;
    complete(0, 32'h0, 1'b0, 6'h06, 1'b1, 32'h600DF00D, lat, acc, nsel);
    chk("bp2_latency", 32'(lat), 32'd3);
    chk("bp2_rsp", {rsp_rdata[30:0], rsp_err}, 32'd0);
    handshake();

    // Reset while in ACCESS abandons the transfer
    issue(1'b0, 6'h15, 32'h0);
    @(negedge pclk);
    @(negedge pclk);
    chk("mid_in_access", 32'(penable), 32'd1);
    preset = 1'b1;
    #1 chk("mid_cmd_ready_in_rst", 32'(cmd_ready), 32'd0);
    @(posedge pclk);
    #1 preset = 1'b0;
    @(negedge pclk);
    chk("mid_psel", 32'(psel), 32'd0);
    chk("mid_penable", 32'(penable), 32'd0);
    chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_paddr", 32'(paddr), 32'd0);
    chk("mid_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (3) @(negedge pclk);
    chk("mid_no_late_rsp", 32'(rsp_valid | psel), 32'd0);
    run_vec(vecs[1]);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
